// File: rtl/dtc_wabs_mc.sv
// dtc_wabs_mc: multi-channel digital-to-time converter.
// Each channel takes a WIDTH-bit code on a trigger and turns its magnitude
// into either a pulse of |code| cycles (mode 0) or a single-cycle edge
// delayed by |code| cycles (mode 1). Channels share only clock and reset.
//
// Per-channel FSM:
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | waiting for trig; only state in which a trigger is accepted
//   RUN    | down-counter active, terminal count at cnt == 1
//   DONE   | one-cycle completion; done strobe, delay-mode output edge
module dtc_wabs_mc #(
  parameter int WIDTH  = 8,
  parameter int NCH    = 4,
  parameter int SIGNED = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NCH*WIDTH-1:0] din,
  input  logic [NCH-1:0]     trig,
  input  logic [NCH-1:0]     mode,
  input  logic [NCH-1:0]     clr_ovr,
  output logic [NCH-1:0]     dtc_out,
  output logic [NCH-1:0]     din_sign,
  output logic [NCH-1:0]     busy,
  output logic [NCH-1:0]     done,
  output logic [NCH-1:0]     overrun
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic [WIDTH-1:0] code;
    logic [WIDTH-1:0] mag;
    logic             sign_in;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    state_t           state_q, state_d;
    logic             accept;
    logic             mode_q;
    logic             sign_q;
    logic             ovr_q;
    logic             dtc_c, busy_c, done_c;

    assign code = din[g*WIDTH +: WIDTH];

    // Magnitude of the incoming code; the most negative code maps to
    // 2^(WIDTH-1), which still fits the unsigned counter.
    always_comb begin
      mag     = code;
      sign_in = 1'b0;
      if ((SIGNED != 0) && code[WIDTH-1]) begin
        mag     = ~code + ONE;
        sign_in = 1'b1;
      end
    end

    // State, counter and acceptance-time latches.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state_q <= S_IDLE;
        cnt_q   <= '0;
        mode_q  <= 1'b0;
        sign_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        if (accept) begin
          mode_q <= mode[g];
          sign_q <= sign_in;
        end
      end
    end

    // Next-state and counter update.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      accept  = 1'b0;
      case (state_q)
        S_IDLE: begin
          if (trig[g]) begin
            accept  = 1'b1;
            cnt_d   = mag;
            state_d = (mag == '0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          cnt_d = cnt_q - ONE;
          if (cnt_q == ONE) state_d = S_DONE;
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end

    // Sticky overrun: a trigger while busy sets it, and wins over a clear.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        ovr_q <= 1'b0;
      end else if (trig[g] && (state_q != S_IDLE)) begin
        ovr_q <= 1'b1;
      end else if (clr_ovr[g]) begin
        ovr_q <= 1'b0;
      end
    end

    // Outputs decoded from registered state only.
    always_comb begin
      dtc_c  = 1'b0;
      busy_c = 1'b0;
      done_c = 1'b0;
      case (state_q)
        S_RUN: begin
          busy_c = 1'b1;
          dtc_c  = ~mode_q;
        end
        S_DONE: begin
          busy_c = 1'b1;
          done_c = 1'b1;
          dtc_c  = mode_q;
        end
        default: ;
      endcase
    end

    assign dtc_out[g]  = dtc_c;
    assign busy[g]     = busy_c;
    assign done[g]     = done_c;
    assign din_sign[g] = sign_q;
    assign overrun[g]  = ovr_q;
  end

endmodule

// File: tb/tb_dtc_wabs_mc.sv
// Bench for dtc_wabs_mc: a signed and an unsigned instance side by side.
// Stimulus pushes the expected conversion per channel; a monitor measures
// each conversion and checks it when the channel strobes done.
module tb_dtc_wabs_mc;
  localparam int W = 8;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N*W-1:0] din_v  [2];
  logic [N-1:0]   trig_v [2];
  logic [N-1:0]   mode_v [2];
  logic [N-1:0]   clr_v  [2];
  logic [N-1:0]   dtc_o  [2];
  logic [N-1:0]   sign_o [2];
  logic [N-1:0]   busy_o [2];
  logic [N-1:0]   done_o [2];
  logic [N-1:0]   ovr_o  [2];

  dtc_wabs_mc #(.WIDTH(W), .NCH(N), .SIGNED(1)) u_dut_s (
    .clk(clk), .rst(rst_n), .din(din_v[0]), .trig(trig_v[0]),
    .mode(mode_v[0]), .clr_ovr(clr_v[0]), .dtc_out(dtc_o[0]),
    .din_sign(sign_o[0]), .busy(busy_o[0]), .done(done_o[0]),
    .overrun(ovr_o[0]));

  dtc_wabs_mc #(.WIDTH(W), .NCH(N), .SIGNED(0)) u_dut_u (
    .clk(clk), .rst(rst_n), .din(din_v[1]), .trig(trig_v[1]),
    .mode(mode_v[1]), .clr_ovr(clr_v[1]), .dtc_out(dtc_o[1]),
    .din_sign(sign_o[1]), .busy(busy_o[1]), .done(done_o[1]),
    .overrun(ovr_o[1]));

  typedef struct packed {
    int   acc;
    int   mag;
    logic mode;
    logic sign;
  } exp_t;

  exp_t sb [8][$];
  int cyc = 0;
  int n_tot = 0;
  int n_bad = 0;
  int hi_cnt [8];
  int bz_cnt [8];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, int act, int exp);
    n_tot++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  function automatic int ref_mag(int d, logic [7:0] code);
    if (d == 0 && code[7]) return 256 - int'(code);
    return int'(code);
  endfunction

  // Monitor: measure each conversion and check it on the done strobe.
  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < N; i++) begin
        int k;
        k = d * N + i;
        if (!rst_n) begin
          hi_cnt[k] = 0;
          bz_cnt[k] = 0;
        end else begin
          if (busy_o[d][i]) bz_cnt[k]++;
          if (dtc_o[d][i])  hi_cnt[k]++;
          if (done_o[d][i]) begin
            if (sb[k].size() == 0) begin
              chk($sformatf("unexpected_done_d%0d_ch%0d", d, i), 1, 0);
            end else begin
              e = sb[k].pop_front();
              chk($sformatf("latency_d%0d_ch%0d", d, i), cyc - e.acc, e.mag);
              chk($sformatf("hi_cycles_d%0d_ch%0d", d, i), hi_cnt[k],
                  e.mode ? 1 : e.mag);
              chk($sformatf("busy_cycles_d%0d_ch%0d", d, i), bz_cnt[k], e.mag + 1);
              chk($sformatf("out_at_done_d%0d_ch%0d", d, i),
                  int'(dtc_o[d][i]), int'(e.mode));
              chk($sformatf("sign_d%0d_ch%0d", d, i),
                  int'(sign_o[d][i]), int'(e.sign));
            end
            hi_cnt[k] = 0;
            bz_cnt[k] = 0;
          end
        end
      end
    end
  end

  task automatic arm(int d, int ch, logic [7:0] code, logic md);
    exp_t e;
    din_v[d][ch*W +: W] = code;
    mode_v[d][ch] = md;
    trig_v[d][ch] = 1'b1;
    e.acc  = cyc + 1;
    e.mag  = ref_mag(d, code);
    e.mode = md;
    e.sign = (d == 0) ? code[7] : 1'b0;
    sb[d*N + ch].push_back(e);
  endtask

  task automatic tick(int n);
    repeat (n) begin
      @(negedge clk);
      trig_v[0] = '0;
      trig_v[1] = '0;
      clr_v[0]  = '0;
      clr_v[1]  = '0;
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      din_v[d] = '0; trig_v[d] = '0; mode_v[d] = '0; clr_v[d] = '0;
    end
    for (int k = 0; k < 8; k++) begin
      hi_cnt[k] = 0; bz_cnt[k] = 0;
    end
    repeat (3) @(negedge clk);
    chk("reset_dtc",   int'(dtc_o[0]),  0);
    chk("reset_busy",  int'(busy_o[0]), 0);
    chk("reset_done",  int'(done_o[0]), 0);
    chk("reset_ovr",   int'(ovr_o[0]),  0);
    chk("reset_sign",  int'(sign_o[0]), 0);
    rst_n = 1'b1;
    tick(2);

    // 50 pulse, -50 delay, -128 pulse, 100 pulse (overrun), unsigned 255
    arm(0, 0, 8'd50, 1'b0);
    arm(0, 1, 8'hCE, 1'b1);
    arm(0, 2, 8'd100, 1'b0);
    arm(0, 3, 8'h80, 1'b0);
    arm(1, 0, 8'hFF, 1'b0);
    tick(1);
    chk("first_busy_ch0",  int'(busy_o[0][0]), 1);
    chk("first_dtc_ch0",   int'(dtc_o[0][0]),  1);
    chk("first_sign_ch0",  int'(sign_o[0][0]), 0);
    chk("first_sign_ch1",  int'(sign_o[0][1]), 1);
    chk("first_dtc_ch1",   int'(dtc_o[0][1]),  0);
    chk("unsigned_sign",   int'(sign_o[1][0]), 0);
    tick(19);
    trig_v[0][2] = 1'b1;
    tick(1);
    chk("ovr_set_ch2",     int'(ovr_o[0][2]), 1);
    chk("ovr_quiet_ch0",   int'(ovr_o[0][0]), 0);
    tick(5);
    trig_v[0][2] = 1'b1;
    clr_v[0][2]  = 1'b1;
    tick(1);
    chk("ovr_set_wins",    int'(ovr_o[0][2]), 1);
    tick(3);
    clr_v[0][2] = 1'b1;
    tick(1);
    chk("ovr_cleared",     int'(ovr_o[0][2]), 0);
    tick(300);

    // zero magnitude in both modes
    arm(0, 0, 8'd0, 1'b0);
    arm(0, 1, 8'd0, 1'b1);
    tick(1);
    chk("zero_done_pulse", int'(done_o[0][0]), 1);
    chk("zero_dtc_pulse",  int'(dtc_o[0][0]),  0);
    chk("zero_dtc_delay",  int'(dtc_o[0][1]),  1);
    tick(3);

    // all channels on one edge, mixed modes
    arm(0, 0, 8'd3, 1'b0);
    arm(0, 1, 8'hF9, 1'b1);
    arm(0, 2, 8'd0, 1'b1);
    arm(0, 3, 8'd12, 1'b0);
    tick(20);

    // reset in the middle of a 100-cycle pulse
    arm(0, 2, 8'd100, 1'b0);
    tick(49);
    trig_v[0][2] = 1'b1;
    tick(1);
    chk("ovr_before_rst",  int'(ovr_o[0][2]), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_dtc",  int'(dtc_o[0]),  0);
    chk("rst_busy", int'(busy_o[0]), 0);
    chk("rst_done", int'(done_o[0]), 0);
    chk("rst_ovr",  int'(ovr_o[0]),  0);
    chk("rst_sign", int'(sign_o[0]), 0);
    for (int k = 0; k < 8; k++) sb[k].delete();
    tick(2);
    rst_n = 1'b1;
    tick(1);
    chk("post_rst_busy", int'(busy_o[0][2]), 0);
    arm(0, 2, 8'd10, 1'b0);
    tick(15);

    tick(5);
    for (int k = 0; k < 8; k++)
      chk($sformatf("pending_k%0d", k), sb[k].size(), 0);
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
